enemy_spawn_scheduler: RTL



---
 rtl/enemy_spawn_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/enemy_spawn_scheduler.sv
// Spawn controller for all enemy pools: per-class interval timers scaled by score level,
// round-robin arbitration between pending classes, lowest-free-slot pick and a global alive cap.
module enemy_spawn_scheduler #(
  parameter int unsigned NUM_CLASS        = 3,
  parameter int unsigned CLASS_BIT_LEN    = 2,
  parameter int unsigned SLOT_NUM         = 10,
  parameter int unsigned SLOT_BIT_LEN     = 4,
  parameter int unsigned BASE_INTERVAL    = 50,
  parameter int unsigned MIN_INTERVAL     = 10,
  parameter int unsigned INTERVAL_BIT_LEN = 9,
  parameter int unsigned LEVEL_STEP       = 5,
  parameter int unsigned LEVEL_MAX        = 7,
  parameter int unsigned LEVEL_BIT_LEN    = 3,
  parameter int unsigned SCORE_PER_LEVEL  = 20,
  parameter int unsigned SCORE_BIT_LEN    = 16,
  parameter int unsigned MAX_ALIVE        = 12,
  parameter int unsigned ALIVE_BIT_LEN    = 5
) (
  input  logic                          clk_run,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic                          pause_i,
  input  logic [SCORE_BIT_LEN-1:0]      score_i,
  input  logic [ALIVE_BIT_LEN-1:0]      alive_cnt_i,
  input  logic [NUM_CLASS*SLOT_NUM-1:0] slot_busy_i,
  output logic [NUM_CLASS-1:0]          trigger_o,
  output logic [SLOT_BIT_LEN-1:0]       trigger_idx_o,
  output logic [LEVEL_BIT_LEN-1:0]      level_o,
  output logic                          spawn_drop_o,
  output logic [1:0]                    state_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [INTERVAL_BIT_LEN-1:0] cnt_q [NUM_CLASS];
  logic [INTERVAL_BIT_LEN-1:0] cnt_d [NUM_CLASS];
  logic [INTERVAL_BIT_LEN-1:0] interval [NUM_CLASS];
  logic [NUM_CLASS-1:0]        pending_q, pending_d;
  logic [CLASS_BIT_LEN-1:0]    ptr_q, ptr_d;
  logic                        cooldown_q, cooldown_d;
  logic [LEVEL_BIT_LEN-1:0]    level_q, level_d;
  logic [NUM_CLASS-1:0]        trigger_q, trigger_d;
  logic [SLOT_BIT_LEN-1:0]     trig_idx_q, trig_idx_d;
  logic                        drop_q, drop_d;

  logic [NUM_CLASS-1:0]        eligible, expire, grant_oh;
  logic                        grant_vld;
  logic [CLASS_BIT_LEN-1:0]    grant_cls, cand;
  logic [SLOT_BIT_LEN-1:0]     grant_slot;
  logic [SLOT_NUM-1:0]         cls_busy;
  int unsigned                 lvl_tgt;

  // Reduced interval, clamped to the floor instead of underflowing.
  function automatic logic [INTERVAL_BIT_LEN-1:0] calc_interval(
    input int unsigned              cls,
    input logic [LEVEL_BIT_LEN-1:0] lvl
  );
    int unsigned base_v, red_v;
    base_v = BASE_INTERVAL * (cls + 1);
    red_v  = LEVEL_STEP * 32'(lvl);
    if (red_v + MIN_INTERVAL >= base_v) begin
      return INTERVAL_BIT_LEN'(MIN_INTERVAL);
    end
    return INTERVAL_BIT_LEN'(base_v - red_v);
  endfunction

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   if (pause_i) state_d = StPause;
        StPause: if (!pause_i) state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < int'(NUM_CLASS); c++) begin
      interval[c] = calc_interval(c, level_q);
      eligible[c] = pending_q[c] & ~(&slot_busy_i[c*SLOT_NUM +: SLOT_NUM]);
    end
  end

  // Round-robin search starts one past the last granted class.
  always_comb begin
    grant_vld = 1'b0;
    grant_cls = '0;
    cand      = ptr_q;
    for (int i = 0; i < int'(NUM_CLASS); i++) begin
      cand = (cand == CLASS_BIT_LEN'(NUM_CLASS - 1)) ? '0 : cand + 1'b1;
      if (!grant_vld && eligible[cand]) begin
        grant_vld = 1'b1;
        grant_cls = cand;
      end
    end
    grant_vld = grant_vld & (state_q == StRun) & (state_d != StIdle) & ~cooldown_q &
                (alive_cnt_i < ALIVE_BIT_LEN'(MAX_ALIVE));
    grant_oh = '0;
    if (grant_vld) grant_oh[grant_cls] = 1'b1;
    cls_busy   = slot_busy_i[grant_cls*SLOT_NUM +: SLOT_NUM];
    grant_slot = '0;
    for (int s = int'(SLOT_NUM) - 1; s >= 0; s--) begin
      if (!cls_busy[s]) grant_slot = SLOT_BIT_LEN'(s);
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    ptr_d      = ptr_q;
    cooldown_d = 1'b0;
    level_d    = level_q;
    trigger_d  = '0;
    trig_idx_d = trig_idx_q;
    drop_d     = 1'b0;
    expire     = '0;
    lvl_tgt    = 32'(score_i) / SCORE_PER_LEVEL;
    if (lvl_tgt > LEVEL_MAX) lvl_tgt = LEVEL_MAX;

    if (state_q == StRun) begin
      // >= so a level rise that shrinks the interval below the count expires immediately.
      for (int c = 0; c < int'(NUM_CLASS); c++) begin
        expire[c] = (cnt_q[c] >= interval[c] - INTERVAL_BIT_LEN'(1));
        cnt_d[c]  = expire[c] ? '0 : cnt_q[c] + INTERVAL_BIT_LEN'(1);
      end
      drop_d    = |(expire & pending_q & ~grant_oh);
      pending_d = (pending_q & ~grant_oh) | expire;
      if (grant_vld) begin
        trigger_d  = grant_oh;
        trig_idx_d = grant_slot;
        ptr_d      = grant_cls;
        cooldown_d = 1'b1;
      end
      if (lvl_tgt > 32'(level_q)) level_d = LEVEL_BIT_LEN'(lvl_tgt);
    end

    if (state_d == StIdle) begin
      for (int c = 0; c < int'(NUM_CLASS); c++) cnt_d[c] = '0;
      pending_d  = '0;
      ptr_d      = '0;
      cooldown_d = 1'b0;
      level_d    = '0;
      trigger_d  = '0;
      drop_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_run) begin
    if (rst) begin
      state_q    <= StIdle;
      for (int c = 0; c < int'(NUM_CLASS); c++) cnt_q[c] <= '0;
      pending_q  <= '0;
      ptr_q      <= '0;
      cooldown_q <= 1'b0;
      level_q    <= '0;
      trigger_q  <= '0;
      trig_idx_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int c = 0; c < int'(NUM_CLASS); c++) cnt_q[c] <= cnt_d[c];
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      cooldown_q <= cooldown_d;
      level_q    <= level_d;
      trigger_q  <= trigger_d;
      trig_idx_q <= trig_idx_d;
      drop_q     <= drop_d;
    end
  end

  assign trigger_o     = trigger_q;
  assign trigger_idx_o = trig_idx_q;
  assign level_o       = level_q;
  assign spawn_drop_o  = drop_q;
  assign state_o       = state_q;

endmodule
